// File: rtl/desempaquetador_fp.sv
// Unpacks two IEEE-754 single operands and produces either aligned sum/difference
// or shift-add mantissa product for the downstream FP normalizer.
//
// state  | meaning
// IDLE   | waiting for start, ready=1
// UNPACK | split fields, order operands, set up align or multiply
// ALIGN  | shift smaller sum operand right one bit per cycle
// ADD    | add/subtract aligned mantissas
// MUL    | one shift-add multiplier step per cycle, LSB first
// DONE   | result fields valid, done pulse
module desempaquetador_fp #(
    parameter int MUL_BITS  = 24,
    parameter int MAX_SHIFT = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        OP_in,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        ready,
    output logic        done,
    output logic        OP_input,
    output logic        Signo_sum,
    output logic [7:0]  Exp_comun,
    output logic [26:0] Suma_resul,
    output logic        Signo_mul,
    output logic [8:0]  Exp_resul,
    output logic [47:0] Producto
);

    localparam int SW = $clog2(MAX_SHIFT + 1);
    localparam int MW = $clog2(MUL_BITS + 1);
    localparam logic [7:0] MAX_SHIFT_W = 8'(MAX_SHIFT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0] a_q, b_q;
    logic        op_q;
    logic [25:0] mant_l, mant_s;
    logic        sign_l, sign_s;
    logic [7:0]  exp_l;
    logic [SW-1:0] shift_cnt;
    logic [47:0] mcand, acc;
    logic [23:0] mult;
    logic [MW-1:0] mul_cnt;
    logic        sgn_mul_q;
    logic [8:0]  exp_mul_q;

    logic [7:0]  exp_a, exp_b, el, es, diff;
    logic [23:0] mant_a, mant_b, ml, ms;
    logic        sl, ss, a_ge_b, far, mul_zero;
    logic [SW-1:0] k_unp;
    logic [8:0]  exp_sum, exp_mul;
    logic [26:0] sum_ext;
    logic        sum_sign, same_sign;
    logic [47:0] acc_nxt;

    // Zero exponent flushes the mantissa; no denormal support.
    always_comb begin
        exp_a  = a_q[30:23];
        exp_b  = b_q[30:23];
        mant_a = (exp_a != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
        mant_b = (exp_b != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
        a_ge_b = {exp_a, mant_a} >= {exp_b, mant_b};
        el     = a_ge_b ? exp_a  : exp_b;
        es     = a_ge_b ? exp_b  : exp_a;
        ml     = a_ge_b ? mant_a : mant_b;
        ms     = a_ge_b ? mant_b : mant_a;
        sl     = a_ge_b ? a_q[31] : b_q[31];
        ss     = a_ge_b ? b_q[31] : a_q[31];
        diff   = el - es;
        far    = (ms == 24'd0) || (diff >= MAX_SHIFT_W);
        k_unp  = far ? '0 : diff[SW-1:0];
        exp_sum  = {1'b0, exp_a} + {1'b0, exp_b};
        exp_mul  = (exp_sum <= 9'd127) ? 9'd0 : (exp_sum - 9'd127);
        mul_zero = (mant_a == 24'd0) || (mant_b == 24'd0);
    end

    // Equal magnitudes with opposite signs give +0.
    always_comb begin
        same_sign = (sign_l == sign_s);
        sum_ext   = same_sign ? ({1'b0, mant_l} + {1'b0, mant_s})
                              : ({1'b0, mant_l} - {1'b0, mant_s});
        sum_sign  = (!same_sign && sum_ext == 27'd0) ? 1'b0 : sign_l;
        acc_nxt   = mult[0] ? (acc + mcand) : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_UNPACK;
            S_UNPACK: begin
                if (op_q) state_nxt = mul_zero ? S_DONE : S_MUL;
                else      state_nxt = (k_unp == '0) ? S_ADD : S_ALIGN;
            end
            S_ALIGN:  if (shift_cnt == SW'(1)) state_nxt = S_ADD;
            S_ADD:    state_nxt = S_DONE;
            S_MUL:    if (mul_cnt == MW'(1)) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            mant_l     <= '0;
            mant_s     <= '0;
            sign_l     <= 1'b0;
            sign_s     <= 1'b0;
            exp_l      <= '0;
            shift_cnt  <= '0;
            mcand      <= '0;
            acc        <= '0;
            mult       <= '0;
            mul_cnt    <= '0;
            sgn_mul_q  <= 1'b0;
            exp_mul_q  <= '0;
            done       <= 1'b0;
            OP_input   <= 1'b0;
            Signo_sum  <= 1'b0;
            Exp_comun  <= '0;
            Suma_resul <= '0;
            Signo_mul  <= 1'b0;
            Exp_resul  <= '0;
            Producto   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= OP_in;
                    end
                end
                S_UNPACK: begin
                    mant_l    <= {ml, 2'b00};
                    mant_s    <= far ? 26'd0 : {ms, 2'b00};
                    sign_l    <= sl;
                    sign_s    <= ss;
                    exp_l     <= el;
                    shift_cnt <= k_unp;
                    mcand     <= {24'd0, mant_a};
                    mult      <= mant_b;
                    acc       <= '0;
                    mul_cnt   <= MW'(MUL_BITS);
                    sgn_mul_q <= a_q[31] ^ b_q[31];
                    exp_mul_q <= exp_mul;
                    if (op_q && mul_zero) begin
                        done      <= 1'b1;
                        OP_input  <= 1'b1;
                        Producto  <= '0;
                        Signo_mul <= a_q[31] ^ b_q[31];
                        Exp_resul <= exp_mul;
                    end
                end
                S_ALIGN: begin
                    mant_s    <= mant_s >> 1;
                    shift_cnt <= shift_cnt - SW'(1);
                end
                S_ADD: begin
                    done       <= 1'b1;
                    OP_input   <= 1'b0;
                    Suma_resul <= sum_ext;
                    Signo_sum  <= sum_sign;
                    Exp_comun  <= exp_l;
                end
                S_MUL: begin
                    acc     <= acc_nxt;
                    mcand   <= mcand << 1;
                    mult    <= mult >> 1;
                    mul_cnt <= mul_cnt - MW'(1);
                    if (mul_cnt == MW'(1)) begin
                        done      <= 1'b1;
                        OP_input  <= 1'b1;
                        Producto  <= acc_nxt;
                        Signo_mul <= sgn_mul_q;
                        Exp_resul <= exp_mul_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
